// File: rtl/bk_sum_buffer.sv
// First-word-fall-through buffer for registered 17-bit adder results,
// with saturating carry-out statistics and a sticky overflow flag.
module bk_sum_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [16:0]              in_sum,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_sum,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CW-1:0]            carry_cnt,
  output logic                     drop_err,
  input  logic                     clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_sum   = mem[rd_ptr][15:0];
  assign out_carry = mem[rd_ptr][16];

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_sum;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A clear wins over a same-cycle carry increment or drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
      drop_err  <= 1'b0;
    end else if (clr_stats) begin
      carry_cnt <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (push && in_sum[16] && (carry_cnt != '1)) begin
        carry_cnt <= carry_cnt + 1'b1;
      end
      if (in_valid && !in_ready) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/bk_sum_buffer.md
BK_SUM_BUFFER -- requirements
Module: bk_sum_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CW, default 8, meaning carry-statistics counter width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  in_sum holds a new registered 17-bit adder result this cycle.
REQ-006 in_sum  input  17  adder result; bit 16 is carry-out, bits 15:0 are the sum.
REQ-007 in_ready  output  1  buffer can accept a word this cycle (advisory; the adder cannot stall).
REQ-008 out_valid  output  1  out_sum/out_carry hold the head entry.
REQ-009 out_ready  input  1  consumer takes the head entry when out_valid is high.
REQ-010 out_sum  output  16  head entry bits 15:0.
REQ-011 out_carry  output  1  head entry bit 16.
REQ-012 level  output  log2(DEPTH)+1  current occupancy.
REQ-013 carry_cnt  output  CW  accepted words with carry-out set, saturating.
REQ-014 drop_err  output  1  sticky flag: a word was lost because the buffer was full.
REQ-015 clr_stats  input  1  synchronous clear of carry_cnt and drop_err.

Function
REQ-016 The buffer SHALL be a first-word-fall-through FIFO: out_valid = (level != 0), out_sum/out_carry = head entry combinationally from storage.
REQ-017 in_ready SHALL equal (level != DEPTH).
REQ-018 A push SHALL occur when in_valid && in_ready; the word is written at the write pointer and visible at the head one cycle later if the FIFO was empty (latency 1 cycle).
REQ-019 A pop SHALL occur when out_valid && out_ready; the read pointer advances at the clock edge.
REQ-020 Simultaneous push and pop SHALL leave level unchanged; with level==DEPTH no push occurs (in_ready low) even if a pop happens that cycle.
REQ-021 in_valid while level==DEPTH SHALL discard the word, set drop_err, and leave storage, pointers and carry_cnt unchanged.
REQ-022 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 out_ready while out_valid low SHALL have no effect; level SHALL never underflow or exceed DEPTH.
REQ-024 carry_cnt SHALL increment by 1 on each push with in_sum[16]=1 and hold at 2^CW-1.
REQ-025 clr_stats SHALL zero carry_cnt and drop_err on the next edge, taking priority over a same-cycle increment or drop; FIFO contents unaffected.
REQ-026 drop_err SHALL remain set until clr_stats or rst.

Reset
REQ-027 While rst is high: pointers=0, level=0, out_valid=0, in_ready=1, carry_cnt=0, drop_err=0; out_sum/out_carry SHALL read 0 (storage cleared).
REQ-028 rst asserted mid-operation SHALL discard all buffered entries immediately (asynchronously); the first push after release SHALL be the first word read.

Verification
REQ-029 Single word: push 0x1_0005 into empty FIFO -> next cycle out_valid=1, out_sum=0x0005, out_carry=1, carry_cnt=1, level=1.
REQ-030 Fill/overflow: 5 pushes 0x00001..0x00005, out_ready=0 -> level=4, in_ready=0, drop_err=1; pops return 1,2,3,4 in order, 0x00005 never appears.
REQ-031 Streaming: in_valid and out_ready high 20 consecutive cycles with incrementing data -> level stays 1 after first cycle, output sequence identical to input, pointers wrap without loss.
REQ-032 Saturation/clear: 300 pushes with bit16=1 while draining -> carry_cnt=255; clr_stats with same-cycle carry push -> carry_cnt=0, drop_err=0.
REQ-033 Async reset: level=3, assert rst between edges -> out_valid=0, level=0 immediately; after release push 0x0_ABCD -> head=0xABCD.
REQ-034 Full with pop: level=4, in_valid and out_ready high -> word dropped, drop_err=1, level=3.
